uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART byte-transmit engine among NUM_REQ word-level requesters (CPU store path, debug/trace printer, exception dumper, ...).
- Each requester presents a 32-bit word and a byte count. The arbiter picks one requester by round-robin and locks onto it.
- It then serialises the selected bytes little-endian (byte 0 = bits [7:0] first) to the engine over a valid/ready handshake, so bytes from different requesters never interleave.
- Sits between the peripheral-side requesters and the UART symbol/shift engine (start, data, odd parity, stop).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_WIDTH, 32, width of each request word; must be a multiple of 8.
- LEN_WIDTH, 2, width of the byte-count field, equal to log2(DATA_WIDTH/8).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until the matching req_ready pulse.
- req_data  in  NUM_REQ*DATA_WIDTH  request words, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  bytes-to-send minus 1, requester i at [i*LEN_WIDTH +: LEN_WIDTH]; 0 means 1 byte, 3 means 4 bytes.
- req_ready  out  NUM_REQ  one-cycle accept pulse; one-hot or zero.
- eng_valid  out  1  byte available to the engine.
- eng_data  out  8  byte to transmit.
- eng_ready  in  1  engine accepts eng_data this cycle.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high while a word is being serialised.
- done  out  1  one-cycle pulse after the last byte of a word is accepted.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Every output is registered.
- Reset values:
  - req_ready=0, eng_valid=0, eng_data=0, grant_id=0, busy=0, done=0.
  - state=IDLE, byte_idx=0, rr_ptr=NUM_REQ-1, so requester 0 wins first.
- State IDLE:
  - If any req_valid bit is high at edge t, grant g = first requester with valid high, searching upward from rr_ptr+1 and wrapping modulo NUM_REQ.
  - At edge t+1, all of the following happen: req_ready[g]=1 for exactly one cycle; word and length are latched; grant_id=g; rr_ptr=g; byte_idx=0; eng_valid=1; eng_data=word[7:0]; busy=1; state=SEND.
  - Latency from req_valid to the first eng_valid is 1 cycle.
- State SEND:
  - eng_valid and eng_data hold stable until eng_ready is high.
  - On a handshake (eng_valid && eng_ready) with byte_idx < len: byte_idx+1 and eng_data = next byte at the next edge. eng_valid stays high, so back-to-back bytes are possible.
  - On a handshake with byte_idx == len: eng_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- Requests raised during SEND are not sampled. Arbitration happens only in IDLE, so there is at least 1 idle cycle between words. That cycle guarantees the just-served requester has dropped req_valid before re-sampling.
- req_valid dropping before req_ready is a protocol violation, and the result is undefined. The bench asserts it never happens.
- req_data and req_len are sampled only on the grant edge; later changes have no effect.
- Width rules:
  - byte_idx is LEN_WIDTH bits and never exceeds len.
  - eng_data = word[byte_idx*8 +: 8].
  - grant_id upper bits are 0 when NUM_REQ < 8.
- Reset mid-word: the partial word is discarded, eng_valid drops at the reset edge and no done is issued. The requester is not re-acked.
- If eng_ready is high while eng_valid is low, nothing happens.

Optional Feature:
- Macro: UART_TX_ARB_PRIO_EN.
- Defined: requester 0 has fixed highest priority. If req_valid[0] is high in IDLE it is granted regardless of rr_ptr, and rr_ptr is not updated. Requesters 1..NUM_REQ-1 round-robin among themselves, using rr_ptr only when req_valid[0] is low.
- Undefined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[31:0]=32'hDDCCBBAA, req_len=3, eng_ready=1 constant -> req_ready[0] pulse 1 cycle after valid; eng_data sequence AA,BB,CC,DD on 4 consecutive cycles; done pulse one cycle later; busy low afterwards.
- req_valid=4'b1111 held, with each requester dropping valid after its ack, len=0, data bytes 0x10..0x13 -> grants in order 0,1,2,3; eng_data 10,11,12,13; exactly one req_ready per word.
- eng_ready toggled 1 cycle high / 3 cycles low during a 2-byte word (len=1, data 16'h5A3C) -> eng_data held at 3C until the handshake, then 5A; no byte duplicated or dropped.
- rst asserted after the 2nd byte handshake of a 4-byte word -> eng_valid=0 and busy=0 the next cycle, no done; the next grant goes to requester 0.
- Requester 2 raises valid while requester 1 is in SEND -> requester 2 gets no ack until after requester 1's done, then is granted 1 cycle after IDLE is entered.
- UART_TX_ARB_PRIO_EN defined, req_valid=4'b0101 continuously re-asserted by requester 0 -> requester 0 granted every time; with the macro undefined, grants alternate 0,2,0,2.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/engine bundle for uart_tx_arbiter: word requests in, byte stream out.
// The arbiter takes the slave view; requesters plus engine together form the master side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          eng_valid;
  logic [7:0]                    eng_data;
  logic                          eng_ready;
  logic [2:0]                    grant_id;
  logic                          busy;
  logic                          done;

  modport master (
    output req_valid, req_data, req_len, eng_ready,
    input  req_ready, eng_valid, eng_data, grant_id, busy, done
  );

  modport slave (
    input  req_valid, req_data, req_len, eng_ready,
    output req_ready, eng_valid, eng_data, grant_id, busy, done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks onto one requester and feeds its word, LSB byte first,
// to the UART byte engine. Define UART_TX_ARB_PRIO_EN to give requester 0 fixed priority.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 2
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                r_state, w_state_d;
  logic [2:0]            r_rr_ptr, w_rr_ptr_d;
  logic [DATA_WIDTH-1:0] r_word, w_word_d;
  logic [LEN_WIDTH-1:0]  r_len, w_len_d;
  logic [LEN_WIDTH-1:0]  r_byte_idx, w_byte_idx_d;
  logic [NUM_REQ-1:0]    r_req_ready, w_req_ready_d;
  logic                  r_eng_valid, w_eng_valid_d;
  logic [7:0]            r_eng_data, w_eng_data_d;
  logic [2:0]            r_grant_id, w_grant_id_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;

  logic                  w_found;
  logic                  w_upd_rr;
  logic [2:0]            w_gnt;
  int unsigned           w_idx;

  // First valid requester searching upward from rr_ptr+1, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_gnt    = '0;
    w_upd_rr = 1'b1;
    w_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[IdxW'(w_idx)]) begin
        w_found = 1'b1;
        w_gnt   = 3'(w_idx);
      end
    end
`ifdef UART_TX_ARB_PRIO_EN
    // Requester 0 overrides the rotation and leaves the pointer untouched.
    if (bus.req_valid[0]) begin
      w_gnt    = '0;
      w_upd_rr = 1'b0;
    end
`endif
  end

  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_word_d      = r_word;
    w_len_d       = r_len;
    w_byte_idx_d  = r_byte_idx;
    w_req_ready_d = '0;
    w_eng_valid_d = r_eng_valid;
    w_eng_data_d  = r_eng_data;
    w_grant_id_d  = r_grant_id;
    w_busy_d      = r_busy;
    w_done_d      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_req_ready_d = NUM_REQ'(1) << w_gnt;
          w_word_d      = bus.req_data[32'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
          w_len_d       = bus.req_len[32'(w_gnt)*LEN_WIDTH +: LEN_WIDTH];
          w_grant_id_d  = w_gnt;
          if (w_upd_rr) w_rr_ptr_d = w_gnt;
          w_byte_idx_d  = '0;
          w_eng_valid_d = 1'b1;
          w_eng_data_d  = bus.req_data[32'(w_gnt)*DATA_WIDTH +: 8];
          w_busy_d      = 1'b1;
          w_state_d     = StSend;
        end
      end
      StSend: begin
        if (r_eng_valid && bus.eng_ready) begin
          if (r_byte_idx != r_len) begin
            // r_word is kept shifted so the next byte is always at [15:8].
            w_byte_idx_d = r_byte_idx + LEN_WIDTH'(1);
            w_word_d     = r_word >> 8;
            w_eng_data_d = r_word[15:8];
          end else begin
            w_eng_valid_d = 1'b0;
            w_busy_d      = 1'b0;
            w_done_d      = 1'b1;
            w_state_d     = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= 3'(NUM_REQ - 1);
      r_word      <= '0;
      r_len       <= '0;
      r_byte_idx  <= '0;
      r_req_ready <= '0;
      r_eng_valid <= 1'b0;
      r_eng_data  <= '0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_word      <= w_word_d;
      r_len       <= w_len_d;
      r_byte_idx  <= w_byte_idx_d;
      r_req_ready <= w_req_ready_d;
      r_eng_valid <= w_eng_valid_d;
      r_eng_data  <= w_eng_data_d;
      r_grant_id  <= w_grant_id_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.eng_valid = r_eng_valid;
  assign bus.eng_data  = r_eng_data;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants/bytes/lengths,
// a negedge monitor pops and compares. Honours UART_TX_ARB_PRIO_EN in its model.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_gnt[$];
  logic [7:0] exp_byte[$];
  int         exp_len[$];
  int         model_ptr = NR - 1;
  int         er_mode   = 0;
  int         cyc       = 0;
  bit         rand_data = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", nm);
  endfunction

  function automatic void push_word(int g, logic [31:0] w, int len);
    exp_gnt.push_back(g);
    for (int b = 0; b <= len; b++) exp_byte.push_back(w[b*8 +: 8]);
    exp_len.push_back(len);
  endfunction

  // Reference order: pending set listed ascending from ptr+1 with wrap; requester 0 first
  // when it has fixed priority.
  task automatic issue_round(input logic [3:0] mask, input logic [127:0] data,
                             input logic [7:0] lens);
    int         ord[$];
    logic [3:0] rr;
    rr = mask;
`ifdef UART_TX_ARB_PRIO_EN
    if (mask[0]) begin
      ord.push_back(0);
      rr[0] = 1'b0;
    end
`endif
    for (int k = 1; k <= int'(NR); k++) begin
      int c;
      c = (model_ptr + k) % NR;
      if (rr[c]) ord.push_back(c);
    end
    if (rr != 0) model_ptr = ord[ord.size()-1];
    foreach (ord[j]) push_word(ord[j], data[ord[j]*32 +: 32], int'(lens[ord[j]*2 +: 2]));
    bus.req_data  = data;
    bus.req_len   = lens;
    bus.req_valid = bus.req_valid | mask;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NR); i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        bus.req_valid[i] = 1'b0;
        if (rand_data) begin
          bus.req_data[i*DW +: DW] = $urandom;
          bus.req_len[i*LW +: LW]  = LW'($urandom);
        end
      end
    end
    case (er_mode)
      0:       bus.eng_ready = 1'b1;
      1:       bus.eng_ready = (cyc % 4 == 0);
      default: bus.eng_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_quiet(string nm, int budget);
    int c;
    c = 0;
    do begin
      drive_cycle();
      c++;
    end while ((bus.req_valid != 0 || bus.busy || bus.req_ready != 0) && c < budget);
    if (bus.req_valid != 0 || bus.busy) fail_now({nm, "_timeout"});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.eng_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_gnt.delete();
    exp_byte.delete();
    exp_len.delete();
    model_ptr = NR - 1;
  endtask

  // Monitor: checks grants, bytes, stall stability and word lengths against the queues.
  initial begin
    int         nbytes;
    int         g;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [3:0] prev_valid;
    nbytes = 0;
    prev_stall = 0;
    prev_data = '0;
    prev_valid = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nbytes = 0;
        prev_stall = 0;
      end else begin
        assert ((prev_valid & ~bus.req_valid & ~bus.req_ready) == '0)
          else $error("req_valid dropped before req_ready");
        if (bus.req_ready != 0) begin
          if (exp_gnt.size() == 0) fail_now("unexpected_grant");
          else begin
            g = exp_gnt.pop_front();
            check("grant_onehot", 32'(bus.req_ready), 32'(1) << g);
            check("grant_id", 32'(bus.grant_id), g);
          end
          nbytes = 0;
        end
        if (prev_stall) check("stall_hold", {bus.eng_valid, bus.eng_data}, {1'b1, prev_data});
        if (bus.eng_valid && bus.eng_ready) begin
          if (exp_byte.size() == 0) fail_now("unexpected_byte");
          else check("eng_data", 32'(bus.eng_data), 32'(exp_byte.pop_front()));
          nbytes++;
        end
        if (bus.done) begin
          if (exp_len.size() == 0) fail_now("unexpected_done");
          else check("done_len", nbytes, exp_len.pop_front() + 1);
          check("done_idle", {bus.busy, bus.eng_valid}, 0);
          nbytes = 0;
        end
        prev_stall = bus.eng_valid && !bus.eng_ready;
        prev_data  = bus.eng_data;
      end
      prev_valid = bus.req_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bit early;
    int acks;
    int g;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_len   = '0;
    bus.eng_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {bus.req_ready, bus.eng_valid, bus.eng_data, bus.grant_id,
                            bus.busy, bus.done}, 0);

    // Single 4-byte word, engine always ready: exact cycle timing.
    er_mode = 0;
    bus.eng_ready = 1'b1;
    issue_round(4'b0001, {96'h0, 32'hDDCCBBAA}, 8'h03);
    @(posedge clk);
    #1;
    check("t1_ack", 32'(bus.req_ready), 1);
    check("t1_first", {bus.eng_valid, bus.eng_data, bus.busy}, {1'b1, 8'hAA, 1'b1});
    bus.req_valid[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("t1_seq", {bus.eng_valid, bus.eng_data}, {1'b1, 8'(8'hAA + k * 8'h11)});
    end
    @(posedge clk);
    #1;
    check("t1_done", {bus.done, bus.busy, bus.eng_valid}, 3'b100);
    @(posedge clk);
    #1;
    check("t1_after", {bus.done, bus.busy}, 0);

    // All four requesters, one byte each.
    do_reset();
    issue_round(4'b1111, {32'h13, 32'h12, 32'h11, 32'h10}, 8'h00);
    run_quiet("t2", 100);

    // Slow engine: 1 cycle ready, 3 cycles stalled.
    er_mode = 1;
    issue_round(4'b0010, {64'h0, 32'h00005A3C, 32'h0}, 8'b00_00_01_00);
    run_quiet("t3", 100);

    // Requester 2 arrives while requester 1 is sending.
    issue_round(4'b0010, {64'h0, 32'h87654321, 32'h0}, 8'b00_00_11_00);
    c = 0;
    do begin
      drive_cycle();
      c++;
    end while (!bus.busy && c < 20);
    issue_round(4'b0100, {32'h0, 32'hCAFEF00D, 64'h0}, 8'b00_11_00_00);
    early = 0;
    c = 0;
    do begin
      drive_cycle();
      c++;
      if (bus.req_ready[2]) early = 1;
    end while (!bus.done && c < 100);
    check("t5_no_early_ack", 32'(early), 0);
    check("t5_done_seen", 32'(bus.done), 1);
    drive_cycle();
    check("t5_ack_after_idle", 32'(bus.req_ready), 32'h4);
    run_quiet("t5", 200);

    // Reset after the second byte of a 4-byte word.
    er_mode = 0;
    bus.eng_ready = 1'b0;
    issue_round(4'b0100, {32'h0, 32'h44332211, 64'h0}, 8'b00_11_00_00);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!bus.req_ready[2] && c < 10);
    check("t4_ack", 32'(bus.req_ready), 32'h4);
    bus.req_valid[2] = 1'b0;
    bus.eng_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.eng_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t4_after_rst", {bus.eng_valid, bus.busy, bus.done}, 0);
    exp_gnt.delete();
    exp_byte.delete();
    exp_len.delete();
    model_ptr = NR - 1;
    issue_round(4'b1001, {32'h0BADF00D, 64'h0, 32'h76543210}, 8'b01_00_00_10);
    run_quiet("t4", 100);

    // Requesters 0 and 2 keep re-requesting.
    do_reset();
    bus.req_data = {32'h0, 32'hA2, 32'h0, 32'hA0};
    bus.req_len  = '0;
    bus.eng_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
`ifdef UART_TX_ARB_PRIO_EN
      g = (n < 4) ? 0 : 2;
`else
      g = (n % 2 == 0) ? 0 : 2;
`endif
      push_word(g, (g == 0) ? 32'hA0 : 32'hA2, 0);
    end
    bus.req_valid = 4'b0101;
    acks = 0;
    c = 0;
    while (bus.req_valid != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      for (int i = 0; i < 4; i += 2) begin
        if (bus.req_ready[i]) begin
          acks++;
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && acks < 4) begin
          bus.req_valid[i] = 1'b1;
        end
      end
    end
    check("t6_acks", acks, 5);
    run_quiet("t6", 50);

    // Randomised rounds.
    do_reset();
    rand_data = 1;
    er_mode = 2;
    for (int r = 0; r < 25; r++) begin
      issue_round(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom},
                  8'($urandom));
      run_quiet("rand", 400);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_gnt.size() + exp_byte.size() + exp_len.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
